// File: rtl/fc_mac_ctrl.sv
// fc_mac_ctrl: sequencer for one saturating MAC lane computing y = W*x, one row at a time.
//
// Each row is processed in three phases:
//   issue - read weight r*N+k and input k for k = 0..N-1
//   drain - no reads; wait while the last products travel through the MAC pipeline
//   out   - present the finished row on y_valid/y_ready
// A tag shift register follows every read through the MAC so that the product-register
// and accumulator enables line up with the data they control.
//
// Parameters:
//   M        output rows (>= 2)
//   N        inputs per row (>= 2)
//   MULT_LAT multiplier latency in cycles (>= 1)
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous reset, active low
//   s_valid/s_ready job request handshake (s_ready high while idle)
//   rd_en           memory read strobe; data reaches the MAC inputs one cycle later
//   addr_w, addr_x  weight address r*N+k, input address k
//   enable_mult     multiplier pipeline enable
//   en_pipeline_reg MAC product-register enable
//   en_acc          MAC accumulator enable
//   clear_acc       MAC accumulator clear
//   y_valid/y_ready row result handshake; y_row is the index of the presented row
//   done            one-cycle pulse when row M-1 is accepted
//
// Build option FC_MAC_CTRL_PERF_EN adds two 32-bit saturating counters, both cleared by
// reset and on job accept:
//   busy_cycles     cycles spent outside idle
//   stall_cycles    cycles with y_valid high and y_ready low

module fc_mac_ctrl #(
    parameter int unsigned M        = 4,
    parameter int unsigned N        = 8,
    parameter int unsigned MULT_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   rd_en,
    output logic [$clog2(M*N)-1:0] addr_w,
    output logic [$clog2(N)-1:0]   addr_x,
    output logic                   enable_mult,
    output logic                   en_pipeline_reg,
    output logic                   en_acc,
    output logic                   clear_acc,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [$clog2(M)-1:0]   y_row,
    output logic                   done
`ifdef FC_MAC_CTRL_PERF_EN
    ,
    output logic [31:0]            busy_cycles,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int unsigned AW       = $clog2(M * N);
    localparam int unsigned AXW      = $clog2(N);
    localparam int unsigned RW       = $clog2(M);
    // One tag stage for each cycle from the read strobe to the accumulator update.
    localparam int unsigned TagDepth = MULT_LAT + 2;
    localparam int unsigned DrainW   = $clog2(TagDepth);

    localparam logic [AXW-1:0]    KLast = AXW'(N - 1);
    localparam logic [RW-1:0]     RLast = RW'(M - 1);
    localparam logic [DrainW-1:0] DLast = DrainW'(TagDepth - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StOut
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_w_q, addr_w_d;
    logic [AXW-1:0]      addr_x_q, addr_x_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic [TagDepth-1:0] tag_q;
    logic                job_accept;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            addr_w_q <= '0;
            addr_x_q <= '0;
            row_q    <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_w_q <= addr_w_d;
            addr_x_q <= addr_x_d;
            row_q    <= row_d;
            drain_q  <= drain_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and decoded outputs
    // ------------------------------------------------------------------
    // addr_x doubles as the column counter k. Because rows are stored back to back,
    // addr_w only ever increments: r*N+N-1 followed by 1 gives (r+1)*N.
    always_comb begin
        state_d     = state_q;
        addr_w_d    = addr_w_q;
        addr_x_d    = addr_x_q;
        row_d       = row_q;
        drain_d     = drain_q;
        s_ready     = 1'b0;
        rd_en       = 1'b0;
        enable_mult = 1'b0;
        y_valid     = 1'b0;
        clear_acc   = 1'b0;
        done        = 1'b0;
        job_accept  = 1'b0;

        case (state_q)
            StIdle: begin
                s_ready = 1'b1;
                // Gating with reset keeps clear_acc low while reset is asserted.
                if (s_valid && reset) begin
                    job_accept = 1'b1;
                    clear_acc  = 1'b1;
                    addr_w_d   = '0;
                    addr_x_d   = '0;
                    row_d      = '0;
                    state_d    = StIssue;
                end
            end

            StIssue: begin
                rd_en       = 1'b1;
                enable_mult = 1'b1;
                if (addr_x_q == KLast) begin
                    // Keep the last address on the bus; only the next row reloads it.
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    addr_x_d = addr_x_q + AXW'(1);
                    addr_w_d = addr_w_q + AW'(1);
                end
            end

            StDrain: begin
                enable_mult = 1'b1;
                if (drain_q == DLast) begin
                    state_d = StOut;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end

            StOut: begin
                y_valid = 1'b1;
                if (y_ready) begin
                    clear_acc = 1'b1;
                    if (row_q == RLast) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d    = row_q + RW'(1);
                        addr_x_d = '0;
                        addr_w_d = addr_w_q + AW'(1);
                        state_d  = StIssue;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tag pipeline: tag_q[i] is rd_en delayed by i+1 cycles
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[TagDepth-2:0], rd_en};
        end
    end

    // The product register loads when the product leaves the multiplier
    // (1 + MULT_LAT cycles after the read). The accumulator adds one cycle later.
    assign en_pipeline_reg = tag_q[MULT_LAT];
    assign en_acc          = tag_q[MULT_LAT+1];

    assign addr_w = addr_w_q;
    assign addr_x = addr_x_q;
    assign y_row  = row_q;

`ifdef FC_MAC_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] busy_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else if (job_accept) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            if ((state_q != StIdle) && (busy_q != '1)) begin
                busy_q <= busy_q + 32'd1;
            end
            if (y_valid && !y_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign busy_cycles  = busy_q;
    assign stall_cycles = stall_q;
`endif

endmodule
